// File: rtl/weight_ram_sequencer_pkg.sv
// Shared types and constants for the weight RAM sequencer.
// Holds the FSM state enum, the default geometry constants and the
// start-request row-count check used by the top-level controller.
package weight_seq_pkg;

  localparam int LANES_DEF  = 10;  // words per RAM row
  localparam int WIDTH_DEF  = 10;  // bits per weight word
  localparam int ADDR_W_DEF = 7;   // RAM address width

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_FILL = 3'd1,
    ST_LOAD_WR   = 3'd2,
    ST_SCAN_RD   = 3'd3,
    ST_SCAN_WAIT = 3'd4,
    ST_SCAN_OUT  = 3'd5,
    ST_DONE      = 3'd6
  } seq_state_t;

  // A request is serviceable only for 1..depth rows.
  function automatic logic row_ok(input int unsigned n, input int unsigned depth);
    return (n != 0) && (n <= depth);
  endfunction

endpackage

// File: rtl/weight_ram_sequencer_if.sv
// Bus bundle between the weight RAM sequencer and its environment.
// Carries start/status, the serial weight stream, the RAM port and the
// output vector stream. master = sequencer side, slave = environment side.
interface weight_ram_sequencer_if
  import weight_seq_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  // control / status
  logic                     load_start;
  logic                     scan_start;
  logic [ADDR_W:0]          num_rows;
  logic                     busy;
  logic                     done;
  logic                     err;
  // serial weight input
  logic                     w_valid;
  logic [WIDTH-1:0]         w_data;
  logic                     w_ready;
  // RAM port
  logic [ADDR_W-1:0]        ram_addr;
  logic                     ram_we;
  logic [LANES*WIDTH-1:0]   ram_d;
  logic [LANES*WIDTH-1:0]   ram_q;
  // vector output
  logic                     vec_valid;
  logic [LANES*WIDTH-1:0]   vec_data;
  logic [ADDR_W-1:0]        vec_addr;
  logic                     vec_ready;

  modport master (
    input  load_start, scan_start, num_rows, w_valid, w_data, ram_q, vec_ready,
    output busy, done, err, w_ready, ram_addr, ram_we, ram_d,
           vec_valid, vec_data, vec_addr
  );

  modport slave (
    output load_start, scan_start, num_rows, w_valid, w_data, ram_q, vec_ready,
    input  busy, done, err, w_ready, ram_addr, ram_we, ram_d,
           vec_valid, vec_data, vec_addr
  );
endinterface

// File: rtl/weight_ram_sequencer_lane_packer.sv
// Packs serial weight words into one RAM row (lane 0 = first word).
// Ports: i_clk/i_rst, i_clear (restart at lane 0), i_push (store i_data in
// the current lane), o_row (packed row), o_last (current lane is the final one).
module weight_lane_packer
  import weight_seq_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  output logic [LANES*WIDTH-1:0] o_row,
  output logic                   o_last
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANE_W-1:0]      r_lane;
  logic [LANES*WIDTH-1:0] r_row;
  logic                   w_last;

  assign w_last = (r_lane == LANE_W'(LANES - 1));
  assign o_last = w_last;
  assign o_row  = r_row;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lane <= '0;
      r_row  <= '0;
    end else if (i_clear) begin
      r_lane <= '0;
    end else if (i_push) begin
      r_row[r_lane*WIDTH +: WIDTH] <= i_data;
      // Wrap after the final lane so the next row starts at lane 0.
      r_lane <= w_last ? '0 : (r_lane + LANE_W'(1));
    end
  end
endmodule

// File: rtl/weight_ram_sequencer.sv
// Sole master of the WeightRAM port: LOAD packs serial words into rows and
// writes them to rows 0..num_rows-1; SCAN reads them back as vectors.
// Ports: i_clk, i_rst (sync, active-high), io_bus (weight_ram_sequencer_if.master).
module weight_ram_sequencer
  import weight_seq_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  weight_ram_sequencer_if.master io_bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] ROW_ONE = {{ADDR_W{1'b0}}, 1'b1};

  seq_state_t             r_state;
  seq_state_t             w_state_nxt;
  logic [ADDR_W:0]        r_row;       // one bit wider so row == DEPTH is reachable
  logic [ADDR_W:0]        r_num_rows;
  logic [LANES*WIDTH-1:0] r_vec_data;
  logic [ADDR_W-1:0]      r_vec_addr;
  logic                   r_err;

  logic                   w_err_req;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_last_lane;
  logic                   w_row_last;
  logic                   w_rows_ok;
  logic [LANES*WIDTH-1:0] w_row_vec;

  assign w_rows_ok  = row_ok(32'(io_bus.num_rows), DEPTH);
  assign w_row_last = ((r_row + ROW_ONE) == r_num_rows);
  assign w_push     = (r_state == ST_LOAD_FILL) && io_bus.w_valid;

  weight_lane_packer #(
    .LANES (LANES),
    .WIDTH (WIDTH)
  ) u_packer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_accept),
    .i_push  (w_push),
    .i_data  (io_bus.w_data),
    .o_row   (w_row_vec),
    .o_last  (w_last_lane)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_err_req   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.load_start) begin
          if (w_rows_ok) begin
            w_state_nxt = ST_LOAD_FILL;
            w_accept    = 1'b1;
          end else begin
            w_err_req = 1'b1;
          end
          // A simultaneous scan request is always dropped.
          if (io_bus.scan_start) w_err_req = 1'b1;
        end else if (io_bus.scan_start) begin
          if (w_rows_ok) begin
            w_state_nxt = ST_SCAN_RD;
            w_accept    = 1'b1;
          end else begin
            w_err_req = 1'b1;
          end
        end
      end
      ST_LOAD_FILL: if (io_bus.w_valid && w_last_lane) w_state_nxt = ST_LOAD_WR;
      ST_LOAD_WR:   w_state_nxt = w_row_last ? ST_DONE : ST_LOAD_FILL;
      ST_SCAN_RD:   w_state_nxt = ST_SCAN_WAIT;
      ST_SCAN_WAIT: w_state_nxt = ST_SCAN_OUT;
      ST_SCAN_OUT:  if (io_bus.vec_ready) w_state_nxt = w_row_last ? ST_DONE : ST_SCAN_RD;
      ST_DONE:      w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
    // Starts while busy are refused without disturbing the operation.
    if (r_state != ST_IDLE && (io_bus.load_start || io_bus.scan_start)) w_err_req = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_row      <= '0;
      r_num_rows <= '0;
      r_vec_data <= '0;
      r_vec_addr <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_req;
      if (w_accept) begin
        r_num_rows <= io_bus.num_rows;
        r_row      <= '0;
      end else if ((r_state == ST_LOAD_WR) ||
                   (r_state == ST_SCAN_OUT && io_bus.vec_ready)) begin
        r_row <= r_row + ROW_ONE;
      end
      // RAM read data is valid in the cycle after the address was presented.
      if (r_state == ST_SCAN_WAIT) begin
        r_vec_data <= io_bus.ram_q;
        r_vec_addr <= r_row[ADDR_W-1:0];
      end
    end
  end

  assign io_bus.w_ready   = (r_state == ST_LOAD_FILL);
  assign io_bus.ram_we    = (r_state == ST_LOAD_WR);
  assign io_bus.ram_addr  = r_row[ADDR_W-1:0];
  assign io_bus.ram_d     = w_row_vec;
  assign io_bus.vec_valid = (r_state == ST_SCAN_OUT);
  assign io_bus.vec_data  = r_vec_data;
  assign io_bus.vec_addr  = r_vec_addr;
  assign io_bus.busy      = (r_state != ST_IDLE);
  assign io_bus.done      = (r_state == ST_DONE);
  assign io_bus.err       = r_err;
endmodule

// File: tb/tb_weight_ram_sequencer.sv
// Directed bench for weight_ram_sequencer with a registered-read RAM model.
// Drives inputs 1 time unit after the rising edge, monitors on the falling edge.
module tb_weight_ram_sequencer;
  import weight_seq_pkg::*;

  localparam int L = LANES_DEF;
  localparam int W = WIDTH_DEF;
  localparam int A = ADDR_W_DEF;
  localparam int VW = L * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weight_ram_sequencer_if #(.LANES(L), .WIDTH(W), .ADDR_W(A)) bus ();

  weight_ram_sequencer #(.LANES(L), .WIDTH(W), .ADDR_W(A)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  // RAM model: registered read, preload port used only by the bench.
  logic [VW-1:0] mem [0:(1<<A)-1];
  logic          pl_en;
  logic [A-1:0]  pl_addr;
  logic [VW-1:0] pl_data;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_d;
    else if (pl_en) mem[pl_addr] <= pl_data;
    bus.ram_q <= mem[bus.ram_addr];
  end

  // Event monitor.
  int            busy_cnt = 0, done_cnt = 0, err_cnt = 0;
  int            wr_addr_q[$];
  logic [VW-1:0] wr_data_q[$];
  int            hs_addr_q[$];
  logic [VW-1:0] hs_data_q[$];
  always @(negedge clk) begin
    if (bus.busy) busy_cnt++;
    if (bus.done) done_cnt++;
    if (bus.err)  err_cnt++;
    if (bus.ram_we) begin
      wr_addr_q.push_back(int'(bus.ram_addr));
      wr_data_q.push_back(bus.ram_d);
    end
    if (bus.vec_valid && bus.vec_ready) begin
      hs_addr_q.push_back(int'(bus.vec_addr));
      hs_data_q.push_back(bus.vec_data);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] load_row(input int base, input int r);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < L; k++) v[k*W +: W] = W'(base + r*L + k);
    return v;
  endfunction

  function automatic logic [VW-1:0] scan_row(input int r);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < L; k++) v[k*W +: W] = W'(r*16 + k);
    return v;
  endfunction

  task automatic check_outs_zero(input string tag);
    check({tag, "_w_ready"},   bus.w_ready,   0);
    check({tag, "_ram_we"},    bus.ram_we,    0);
    check({tag, "_ram_addr"},  bus.ram_addr,  0);
    check({tag, "_ram_d"},     bus.ram_d,     0);
    check({tag, "_vec_valid"}, bus.vec_valid, 0);
    check({tag, "_vec_data"},  bus.vec_data,  0);
    check({tag, "_vec_addr"},  bus.vec_addr,  0);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_done"},      bus.done,      0);
    check({tag, "_err"},       bus.err,       0);
  endtask

  // Start a LOAD of n rows fed with words base, base+1, ... and wait for done.
  task automatic run_load(input int n, input int base, input logic also_scan);
    int word, cyc, d0;
    logic hs;
    d0 = done_cnt;
    bus.num_rows   = (A+1)'(n);
    bus.load_start = 1'b1;
    bus.scan_start = also_scan;
    step();
    bus.load_start = 1'b0;
    bus.scan_start = 1'b0;
    bus.w_valid = 1'b1;
    word = 0;
    cyc  = 0;
    while (word < n*L && cyc < n*L*2 + 50) begin
      bus.w_data = W'(base + word);
      hs = bus.w_ready;
      step();
      if (hs) word++;
      cyc++;
    end
    bus.w_valid = 1'b0;
    cyc = 0;
    while (done_cnt == d0 && cyc < 20) begin
      step();
      cyc++;
    end
    check("load_done_pulse", done_cnt - d0, 1);
  endtask

  initial begin
    int b0, w0, h0, e0, d0, cyc, stall;
    logic [VW-1:0] snap;
    int bad;

    rst = 1'b1;
    bus.load_start = 0; bus.scan_start = 0; bus.num_rows = 0;
    bus.w_valid = 0; bus.w_data = 0; bus.vec_ready = 0;
    pl_en = 0; pl_addr = 0; pl_data = 0;
    step(); step();
    check_outs_zero("reset");
    rst = 1'b0;
    step();

    // LOAD of 2 rows, words 1..20 back to back.
    b0 = busy_cnt; w0 = wr_addr_q.size();
    run_load(2, 1, 1'b0);
    check("load2_writes", wr_addr_q.size() - w0, 2);
    check("load2_addr0",  wr_addr_q[w0],   0);
    check("load2_data0",  wr_data_q[w0],   load_row(1, 0));
    check("load2_addr1",  wr_addr_q[w0+1], 1);
    check("load2_data1",  wr_data_q[w0+1], load_row(1, 1));
    check("load2_busy_cycles", busy_cnt - b0, 23);

    // Preload rows 0..2 with r*16+k.
    for (int r = 0; r < 3; r++) begin
      pl_en = 1'b1; pl_addr = A'(r); pl_data = scan_row(r);
      step();
    end
    pl_en = 1'b0;

    // SCAN of 3 rows with vec_ready high.
    w0 = wr_addr_q.size(); h0 = hs_addr_q.size(); d0 = done_cnt;
    bus.vec_ready = 1'b1;
    bus.num_rows = 3; bus.scan_start = 1'b1;
    step();
    bus.scan_start = 1'b0;
    cyc = 1;
    while (!bus.vec_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check("scan_first_latency", cyc, 3);
    cyc = 0;
    while (done_cnt == d0 && cyc < 50) begin
      step();
      cyc++;
    end
    bus.vec_ready = 1'b0;
    check("scan_done_pulse", done_cnt - d0, 1);
    check("scan_vectors", hs_addr_q.size() - h0, 3);
    for (int r = 0; r < 3; r++) begin
      if (hs_addr_q.size() > h0 + r) begin
        check("scan_vec_addr", hs_addr_q[h0+r], r);
        check("scan_vec_data", hs_data_q[h0+r], scan_row(r));
      end
    end
    check("scan_no_write", wr_addr_q.size() - w0, 0);

    // SCAN with a 5-cycle stall on row 1.
    b0 = busy_cnt; h0 = hs_addr_q.size(); d0 = done_cnt;
    bus.num_rows = 3; bus.scan_start = 1'b1;
    step();
    bus.scan_start = 1'b0;
    cyc = 0; stall = 0; snap = '0;
    while (done_cnt == d0 && cyc < 100) begin
      if (bus.vec_valid && bus.vec_addr == 1 && stall < 5) begin
        if (stall == 0) begin
          snap = bus.vec_data;
          check("stall_data", snap, scan_row(1));
        end else begin
          check("stall_hold_data",  bus.vec_data,  snap);
          check("stall_hold_addr",  bus.vec_addr,  1);
        end
        stall++;
        bus.vec_ready = 1'b0;
      end else begin
        bus.vec_ready = bus.vec_valid;
      end
      step();
      cyc++;
    end
    bus.vec_ready = 1'b0;
    check("stall_vectors", hs_addr_q.size() - h0, 3);
    if (hs_addr_q.size() >= h0 + 3) begin
      check("stall_row1_once", hs_addr_q[h0+1], 1);
      check("stall_row2_addr", hs_addr_q[h0+2], 2);
    end
    check("stall_busy_cycles", busy_cnt - b0, 15);

    // Both starts at once: LOAD wins, one err.
    e0 = err_cnt; w0 = wr_addr_q.size();
    run_load(1, 50, 1'b1);
    check("both_err", err_cnt - e0, 1);
    check("both_writes", wr_addr_q.size() - w0, 1);

    // Illegal row counts are refused.
    e0 = err_cnt; b0 = busy_cnt;
    bus.num_rows = 0; bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    check("rows0_err_out", bus.err, 1);
    bus.num_rows = 129; bus.scan_start = 1'b1;
    step();
    bus.scan_start = 1'b0;
    step(); step();
    check("rows_bad_err_cnt", err_cnt - e0, 2);
    check("rows_bad_busy", busy_cnt - b0, 0);

    // Reset after 4 of 10 words.
    w0 = wr_addr_q.size();
    bus.num_rows = 1; bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    bus.w_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.w_data = W'(100 + i);
      step();
    end
    rst = 1'b1;
    step();
    check_outs_zero("midrst");
    rst = 1'b0;
    bus.w_valid = 1'b0;
    step(); step(); step();
    check("midrst_no_write", wr_addr_q.size() - w0, 0);
    w0 = wr_addr_q.size();
    run_load(1, 200, 1'b0);
    check("fresh_writes", wr_addr_q.size() - w0, 1);
    if (wr_addr_q.size() > w0) begin
      check("fresh_addr", wr_addr_q[w0], 0);
      check("fresh_data", wr_data_q[w0], load_row(200, 0));
    end

    // Full-depth LOAD of 128 rows.
    w0 = wr_addr_q.size();
    run_load(128, 0, 1'b0);
    step(); step(); step(); step();
    check("full_writes", wr_addr_q.size() - w0, 128);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size() - w0; i++)
      if (wr_addr_q[w0+i] != i) bad++;
    check("full_addr_sequence", bad, 0);
    if (wr_addr_q.size() >= w0 + 128) begin
      check("full_last_addr", wr_addr_q[w0+127], 127);
      check("full_last_data", wr_data_q[w0+127], load_row(0, 127));
    end
    check("full_idle_after", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
